// File: rtl/mem_access.sv
// Memory-access pipeline stage: holds one instruction, issues at most one
// data-SRAM transaction for it, and hands the payload plus load data to WB.
module mem_access (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ms_allowin,
   input  logic [7:0]  ex_op,
   input  logic [1:0]  ex_access_sz,
   input  logic [31:0] ex_out,
   input  logic [4:0]  ex_reg_d,
   input  logic [31:0] ex_st_data,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [31:0] data_sram_addr,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   input  logic        wb_allowin,
   output logic        ms_to_wb_valid,
   output logic [7:0]  wb_op,
   output logic [4:0]  wb_reg_d,
   output logic [31:0] wb_exe_out,
   output logic [1:0]  wb_mm_access_sz,
   output logic [31:0] wb_rdata
);

   localparam logic [7:0] OP_LD  = 8'h10;
   localparam logic [7:0] OP_LDU = 8'h11;
   localparam logic [7:0] OP_LL  = 8'h12;
   localparam logic [7:0] OP_ST  = 8'h13;

   localparam logic [1:0] ACCESS_SZ_BYTE = 2'd0;
   localparam logic [1:0] ACCESS_SZ_HALF = 2'd1;
   localparam logic [1:0] ACCESS_SZ_WORD = 2'd2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic        ms_valid;
   logic [1:0]  state;
   logic [7:0]  pl_op;
   logic [4:0]  pl_reg_d;
   logic [31:0] pl_exe_out;
   logic [1:0]  pl_sz;
   logic [31:0] pl_st_data;
   logic [31:0] rdata_buf;

   logic is_mem;
   logic is_store;
   logic ms_ready_go;
   logic accept;

   function automatic logic is_mem_op(input logic [7:0] op);
      return (op == OP_LD) || (op == OP_LDU) || (op == OP_LL) || (op == OP_ST);
   endfunction

   assign is_mem         = is_mem_op(pl_op);
   assign is_store       = (pl_op == OP_ST);
   assign ms_ready_go    = !is_mem || (state == S_DONE);
   assign ms_allowin     = !ms_valid || (ms_ready_go && wb_allowin);
   assign ms_to_wb_valid = ms_valid && ms_ready_go;
   assign accept         = ex_valid && ms_allowin;

   // Request fields come straight from the payload registers, so they stay
   // stable for as long as req is held waiting for addr_ok.
   assign data_sram_req  = ms_valid && (state == S_REQ);
   assign data_sram_wr   = is_store;
   assign data_sram_size = pl_sz;
   assign data_sram_addr = pl_exe_out;

   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = pl_st_data;
      case (pl_sz)
         ACCESS_SZ_BYTE: begin
            data_sram_wdata = {4{pl_st_data[7:0]}};
            if (is_store) data_sram_wstrb = 4'b0001 << pl_exe_out[1:0];
         end
         ACCESS_SZ_HALF: begin
            data_sram_wdata = {2{pl_st_data[15:0]}};
            if (is_store) data_sram_wstrb = 4'b0011 << pl_exe_out[1:0];
         end
         ACCESS_SZ_WORD: begin
            if (is_store) data_sram_wstrb = 4'b1111;
         end
         default: ;
      endcase
   end

   // NOTE: reset is synchronous, so it is simply the highest-priority branch
   // of the clocked block; all state uses non-blocking assignments.
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid   <= 1'b0;
         state      <= S_IDLE;
         pl_op      <= '0;
         pl_reg_d   <= '0;
         pl_exe_out <= '0;
         pl_sz      <= '0;
         pl_st_data <= '0;
         rdata_buf  <= '0;
      end else if (accept) begin
         ms_valid   <= 1'b1;
         pl_op      <= ex_op;
         pl_reg_d   <= ex_reg_d;
         pl_exe_out <= ex_out;
         pl_sz      <= ex_access_sz;
         pl_st_data <= ex_st_data;
         state      <= is_mem_op(ex_op) ? S_REQ : S_IDLE;
      end else if (ms_allowin) begin
         ms_valid <= 1'b0;
         state    <= S_IDLE;
      end else begin
         case (state)
            S_REQ:  if (data_sram_addr_ok) state <= S_WAIT;
            S_WAIT: if (data_sram_data_ok) begin
               rdata_buf <= is_store ? 32'h0
                                     : (data_sram_rdata >> {pl_exe_out[1:0], 3'b000});
               state     <= S_DONE;
            end
            default: ;
         endcase
      end
   end

   assign wb_op           = pl_op;
   assign wb_reg_d        = pl_reg_d;
   assign wb_exe_out      = pl_exe_out;
   assign wb_mm_access_sz = pl_sz;
   assign wb_rdata        = rdata_buf;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected SRAM requests and WB handoffs are
// queued at issue time and popped when the DUT produces them.
module tb_mem_access;

   localparam logic [7:0] OP_ALU = 8'h01;
   localparam logic [7:0] OP_ALU2 = 8'h02;
   localparam logic [7:0] OP_LD  = 8'h10;
   localparam logic [7:0] OP_LDU = 8'h11;
   localparam logic [7:0] OP_LL  = 8'h12;
   localparam logic [7:0] OP_ST  = 8'h13;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef struct packed {
      logic [7:0]  op;
      logic [4:0]  reg_d;
      logic [31:0] exe_out;
      logic [1:0]  sz;
      logic [31:0] rdata;
   } wb_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid = 1'b0;
   logic [7:0]  ex_op = '0;
   logic [1:0]  ex_access_sz = '0;
   logic [31:0] ex_out = '0;
   logic [4:0]  ex_reg_d = '0;
   logic [31:0] ex_st_data = '0;
   logic        wb_allowin = 1'b1;

   logic        ms_allowin, data_sram_req, data_sram_wr, ms_to_wb_valid;
   logic [1:0]  data_sram_size, wb_mm_access_sz;
   logic [31:0] data_sram_addr, data_sram_wdata, wb_exe_out, wb_rdata;
   logic [3:0]  data_sram_wstrb;
   logic [7:0]  wb_op;
   logic [4:0]  wb_reg_d;

   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   // Responder outputs, or manual pulses when the responder is switched off.
   logic        resp_en = 1'b1;
   logic        r_addr_ok = 1'b0, r_data_ok = 1'b0;
   logic [31:0] r_rdata = '0;
   logic        man_data_ok = 1'b0;
   logic [31:0] man_rdata = '0;
   int          ok_delay = 0, data_delay = 0;
   bit          pending = 0;
   int          req_cycles = 0, wait_cycles = 0;

   assign data_sram_addr_ok = resp_en & r_addr_ok;
   assign data_sram_data_ok = resp_en ? r_data_ok : man_data_ok;
   assign data_sram_rdata   = resp_en ? r_rdata : man_rdata;

   wb_t         wb_q[$];
   req_t        req_q[$];
   logic [31:0] model_rdata = '0;
   int          n_vec = 0, n_err = 0;
   bit          req_open = 0;
   req_t        got_req;
   wb_t         got_wb;

   mem_access dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ms_allowin(ms_allowin),
      .ex_op(ex_op), .ex_access_sz(ex_access_sz), .ex_out(ex_out),
      .ex_reg_d(ex_reg_d), .ex_st_data(ex_st_data),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin),
      .ms_to_wb_valid(ms_to_wb_valid), .wb_op(wb_op), .wb_reg_d(wb_reg_d),
      .wb_exe_out(wb_exe_out), .wb_mm_access_sz(wb_mm_access_sz), .wb_rdata(wb_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:2] == 30'h40) return 32'hAB00_0000;
      return {~a[15:0], a[15:0] ^ 16'h5A3C};
   endfunction

   // Word-aligned SRAM model driving addr_ok/data_ok with programmable delays.
   initial begin
      forever begin
         @(posedge clk); #1;
         r_addr_ok = 1'b0;
         r_data_ok = 1'b0;
         r_rdata   = 32'hDEAD_BEEF;
         if (reset || !resp_en) begin
            pending    = 0;
            req_cycles = 0;
         end else if (pending) begin
            wait_cycles++;
            if (wait_cycles > data_delay) begin
               r_data_ok = 1'b1;
               r_rdata   = mem_word({data_sram_addr[31:2], 2'b00});
               pending   = 0;
            end
         end else if (data_sram_req) begin
            if (req_cycles >= ok_delay) begin
               r_addr_ok   = 1'b1;
               pending     = 1;
               wait_cycles = 0;
               req_cycles  = 0;
            end else begin
               req_cycles++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         req_open = 0;
      end else begin
         if (req_open) chk("req_held", data_sram_req, 1'b1);
         if (data_sram_req) begin
            chk("req_expected", req_q.size() != 0, 1'b1);
            if (req_q.size() != 0) begin
               got_req.wr    = data_sram_wr;
               got_req.size  = data_sram_size;
               got_req.addr  = data_sram_addr;
               got_req.wstrb = data_sram_wstrb;
               got_req.wdata = req_q[0].wr ? data_sram_wdata : 32'h0;
               chk("req_fields", got_req, req_q[0]);
               if (data_sram_addr_ok) void'(req_q.pop_front());
            end
         end
         req_open = data_sram_req && !data_sram_addr_ok;
         if (ms_to_wb_valid && wb_allowin) begin
            chk("wb_expected", wb_q.size() != 0, 1'b1);
            if (wb_q.size() != 0) begin
               got_wb.op      = wb_op;
               got_wb.reg_d   = wb_reg_d;
               got_wb.exe_out = wb_exe_out;
               got_wb.sz      = wb_mm_access_sz;
               got_wb.rdata   = wb_rdata;
               chk("wb_payload", got_wb, wb_q.pop_front());
            end
         end
      end
   end

   task automatic expect_push(input logic [7:0] op, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [4:0] rd,
                              input logic [31:0] st);
      wb_t  w;
      req_t r;
      bit   mem;
      int   off, nbytes;
      mem       = op inside {OP_LD, OP_LDU, OP_LL, OP_ST};
      w.op      = op;
      w.reg_d   = rd;
      w.exe_out = addr;
      w.sz      = sz;
      if (!mem)             w.rdata = model_rdata;
      else if (op == OP_ST) w.rdata = 32'h0;
      else                  w.rdata = mem_word({addr[31:2], 2'b00}) >> (8 * int'(addr[1:0]));
      model_rdata = w.rdata;
      wb_q.push_back(w);
      if (mem) begin
         off     = int'(addr[1:0]);
         nbytes  = 1 << int'(sz);
         r.wr    = (op == OP_ST);
         r.size  = sz;
         r.addr  = addr;
         r.wstrb = 4'b0000;
         r.wdata = 32'h0;
         if (r.wr) begin
            for (int i = 0; i < 4; i++) r.wstrb[i] = (i >= off) && (i < off + nbytes);
            case (sz)
               SZ_B:    r.wdata = {4{st[7:0]}};
               SZ_H:    r.wdata = {2{st[15:0]}};
               default: r.wdata = st;
            endcase
         end
         req_q.push_back(r);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
   task automatic issue(input logic [7:0] op, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] st);
      int n = 0;
      expect_push(op, sz, addr, rd, st);
      ex_valid = 1'b1; ex_op = op; ex_access_sz = sz;
      ex_out = addr; ex_reg_d = rd; ex_st_data = st;
      #1;
      while (!ms_allowin && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      chk("issue_accept", n < 100, 1'b1);
      @(posedge clk); #1;
      ex_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (wb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain", wb_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a valid non-memory op presented: it must be ignored.
      ex_valid = 1'b1; ex_op = OP_ALU; ex_out = 32'h77; ex_reg_d = 5'd1;
      repeat (3) begin @(posedge clk); #1; end
      #1;
      chk("rst_req", data_sram_req, 1'b0);
      chk("rst_wbvalid", ms_to_wb_valid, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0; ex_valid = 1'b0;
      #1;
      chk("rst_allowin", ms_allowin, 1'b1);
      chk("rst_rdata", wb_rdata, 32'h0);
      chk("rst_payload", {wb_op, wb_reg_d, wb_exe_out, wb_mm_access_sz}, 47'h0);
      @(posedge clk); #1;
      #1;
      chk("rst_no_accept", ms_to_wb_valid, 1'b0);
      @(posedge clk); #1;

      // Non-memory op: valid the next cycle, no request.
      issue(OP_ALU, SZ_W, 32'h1234, 5'd5, 32'h0);
      #1;
      chk("alu_valid", ms_to_wb_valid, 1'b1);
      chk("alu_exe_out", wb_exe_out, 32'h1234);
      chk("alu_reg_d", wb_reg_d, 5'd5);
      chk("alu_no_req", data_sram_req, 1'b0);
      @(posedge clk); #2;
      chk("alu_gone", ms_to_wb_valid, 1'b0);
      @(posedge clk); #1;

      // Byte load at 0x103: addr_ok after 2 waiting req cycles, data_ok next.
      ok_delay = 2; data_delay = 0;
      issue(OP_LD, SZ_B, 32'h103, 5'd6, 32'h0);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("ldb_req", data_sram_req, 1'b1);
         chk("ldb_size", data_sram_size, 2'd0);
         chk("ldb_wstrb", data_sram_wstrb, 4'b0000);
         chk("ldb_addr", data_sram_addr, 32'h103);
         @(posedge clk); #2;
      end
      chk("ldb_req_drop", data_sram_req, 1'b0);
      chk("ldb_not_yet", ms_to_wb_valid, 1'b0);
      @(posedge clk); #2;
      chk("ldb_valid", ms_to_wb_valid, 1'b1);
      chk("ldb_rdata", wb_rdata, 32'h0000_00AB);
      drain();

      // Half store at 0x202: valid only after data_ok.
      ok_delay = 0; data_delay = 2;
      issue(OP_ST, SZ_H, 32'h202, 5'd0, 32'h0000_BEEF);
      #1;
      chk("sth_wr", data_sram_wr, 1'b1);
      chk("sth_wstrb", data_sram_wstrb, 4'b1100);
      chk("sth_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      for (int i = 0; i < 4; i++) begin
         chk("sth_not_yet", ms_to_wb_valid, 1'b0);
         @(posedge clk); #2;
      end
      chk("sth_valid", ms_to_wb_valid, 1'b1);
      drain();

      // Load stalled in DONE by WB, then handoff and new accept on one edge.
      wb_allowin = 1'b0; ok_delay = 0; data_delay = 0;
      issue(OP_LD, SZ_W, 32'h300, 5'd9, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      expect_push(OP_ALU2, SZ_B, 32'h55, 5'd7, 32'h0);
      ex_valid = 1'b1; ex_op = OP_ALU2; ex_access_sz = SZ_B;
      ex_out = 32'h55; ex_reg_d = 5'd7;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_allowin", ms_allowin, 1'b0);
         chk("stall_valid", ms_to_wb_valid, 1'b1);
         chk("stall_rdata", wb_rdata, mem_word(32'h300));
         @(posedge clk); #1;
      end
      wb_allowin = 1'b1;
      #1;
      chk("unstall_allowin", ms_allowin, 1'b1);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      #1;
      chk("b2b_valid", ms_to_wb_valid, 1'b1);
      chk("b2b_exe_out", wb_exe_out, 32'h55);
      chk("b2b_reg_d", wb_reg_d, 5'd7);
      drain();

      // Reset while waiting for data_ok; a late data_ok must be ignored.
      ok_delay = 0; data_delay = 10;
      issue(OP_LD, SZ_W, 32'h400, 5'd3, 32'h0);
      @(posedge clk); #2;
      chk("abort_in_wait", data_sram_req, 1'b0);
      reset = 1'b1; resp_en = 1'b0;
      wb_q.delete();
      model_rdata = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      man_data_ok = 1'b1; man_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      man_data_ok = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("abort_valid", ms_to_wb_valid, 1'b0);
         chk("abort_req", data_sram_req, 1'b0);
         chk("abort_rdata", wb_rdata, 32'h0);
         chk("abort_allowin", ms_allowin, 1'b1);
         @(posedge clk); #1;
      end

      // Stray data_ok while idle, then a back-to-back LD/LDU pair.
      man_data_ok = 1'b1; man_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      man_data_ok = 1'b0;
      #1;
      chk("stray_valid", ms_to_wb_valid, 1'b0);
      chk("stray_rdata", wb_rdata, 32'h0);
      @(posedge clk); #1;
      resp_en = 1'b1; ok_delay = 1; data_delay = 1;
      issue(OP_LD, SZ_H, 32'h502, 5'd10, 32'h0);
      issue(OP_LDU, SZ_B, 32'h601, 5'd11, 32'h0);
      #1;
      chk("b2b_req", data_sram_req, 1'b1);
      chk("b2b_addr", data_sram_addr, 32'h601);
      @(posedge clk); #1;
      drain();

      // Every byte lane for stores and loads, plus an LL half load.
      for (int off = 0; off < 4; off++) begin
         ok_delay = off % 2; data_delay = off;
         issue(OP_ST, SZ_B, 32'h700 + off, 5'd0, 32'hC0DE_0A00 + off);
         issue(OP_LD, SZ_B, 32'h900 + off, 5'd12 + off[4:0], 32'h0);
      end
      issue(OP_ST, SZ_W, 32'hA00, 5'd0, 32'h0BAD_F00D);
      issue(OP_LL, SZ_H, 32'hB02, 5'd20, 32'h0);
      issue(OP_ST, SZ_H, 32'hC00, 5'd0, 32'h1111_2222);
      drain();
      chk("req_q_drained", req_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
